// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and SRAM geometry for the word controller
package sram_ctrl_pkg;
    localparam int SRAM_AW = 10;
    localparam int SRAM_DW = 8;
    typedef enum logic [2:0] {IDLE, CPU_ACC, TAIL, RESP, LD_WR} state_t;
    typedef enum logic {GNT_CPU, GNT_LD} grant_t;
endpackage

// File: rtl/sram_rr_arb.sv
// sram_rr_arb: two-requester round-robin arbiter, loader counts as last winner after reset
module sram_rr_arb
    import sram_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_cpu,
    input  logic req_ld,
    output logic gnt_cpu,
    output logic gnt_ld
);
    grant_t last;
    assign gnt_cpu = en && req_cpu && (!req_ld || last == GNT_LD);
    assign gnt_ld  = en && req_ld && !gnt_cpu;
    // remember the most recent winner so a tie goes to the other side
    always_ff @(posedge clk or posedge rst)
        if (rst) last <= GNT_LD;
        else if (gnt_cpu) last <= GNT_CPU;
        else if (gnt_ld) last <= GNT_LD;
endmodule

// File: rtl/sram_word_ctrl.sv
// sram_word_ctrl: 32-bit picorv32 port and byte loader sharing one 8x1024 OpenRAM
module sram_word_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_valid,
    input  logic               mem_instr,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    input  logic [3:0]         mem_wstrb,
    output logic               mem_ready,
    output logic [31:0]        mem_rdata,
    input  logic               ld_valid,
    input  logic [SRAM_AW-1:0] ld_addr,
    input  logic [SRAM_DW-1:0] ld_data,
    output logic               ld_ready,
    output logic               sram_csb,
    output logic               sram_web,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_din,
    input  logic [SRAM_DW-1:0] sram_dout,
    output logic               busy,
    output logic               err
);
    state_t      state, nxt;
    logic [1:0]  k, prev;
    logic [7:0]  word;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        hit, hit_now, wr, gnt_cpu, gnt_ld, unused;
    assign hit_now = mem_addr[31:10] == BASE_ADDR[31:10];
    assign wr      = |wstrb;
    assign prev    = k - 2'd1;
    assign busy    = state != IDLE;
    assign unused  = ^{mem_instr, mem_addr[1:0]};
    sram_rr_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (state == IDLE),
        .req_cpu(mem_valid),
        .req_ld (ld_valid),
        .gnt_cpu(gnt_cpu),
        .gnt_ld (gnt_ld)
    );
    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= nxt;
    // request latch, byte counter, read assembly and sticky range error
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            k     <= 2'd0;
            word  <= 8'd0;
            wdata <= 32'd0;
            wstrb <= 4'd0;
            hit   <= 1'b0;
            rdata <= 32'd0;
            err   <= 1'b0;
        end else begin
            k <= state == CPU_ACC ? k + 2'd1 : 2'd0;
            if (gnt_cpu) begin
                word  <= mem_addr[9:2];
                wdata <= mem_wdata;
                wstrb <= mem_wstrb;
                hit   <= hit_now;
                err   <= err | !hit_now;
            end
            if ((state == CPU_ACC && k != 2'd0) || state == TAIL) rdata[{prev, 3'b000} +: 8] <= sram_dout;
        end
    // next state and all port outputs, idle values first
    always_comb begin
        nxt       = state;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        ld_ready  = 1'b0;
        sram_csb  = 1'b1;
        sram_web  = 1'b1;
        sram_addr = '0;
        sram_din  = '0;
        case (state)
            IDLE:    nxt = gnt_cpu ? (hit_now ? CPU_ACC : RESP) : gnt_ld ? LD_WR : IDLE;
            CPU_ACC: begin
                nxt       = k == 2'd3 ? TAIL : CPU_ACC;
                sram_addr = {word, k};
                sram_din  = wdata[{k, 3'b000} +: 8];
                sram_csb  = wr & !wstrb[k];
                sram_web  = wr ? !wstrb[k] : 1'b1;
            end
            TAIL:    nxt = RESP;
            RESP: begin
                nxt       = IDLE;
                mem_ready = 1'b1;
                mem_rdata = hit && !wr ? rdata : 32'd0;
            end
            LD_WR: begin
                nxt       = IDLE;
                ld_ready  = 1'b1;
                sram_csb  = 1'b0;
                sram_web  = 1'b0;
                sram_addr = ld_addr;
                sram_din  = ld_data;
            end
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sram_word_ctrl.sv
// tb_sram_word_ctrl: directed and random checks against a byte-array memory model
module tb_sram_word_ctrl;
    logic        clk = 0, rst = 0, clr = 1;
    logic        mem_valid = 0, mem_instr = 0, mem_ready;
    logic [31:0] mem_addr = 0, mem_wdata = 0, mem_rdata;
    logic [3:0]  mem_wstrb = 0;
    logic        ld_valid = 0, ld_ready;
    logic [9:0]  ld_addr = 0, sram_addr;
    logic [7:0]  ld_data = 0, sram_din, sram_dout;
    logic        sram_csb, sram_web, busy, err;
    logic [7:0]  sram [1024];
    logic [7:0]  ref_mem [1024];
    int          wr_cnt = 0, en_cnt = 0;
    int          compared = 0, mismatched = 0;

    sram_word_ctrl dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // behavioural OpenRAM port: synchronous write, read data one cycle after enable
    always @(posedge clk) begin
        if (clr) for (int i = 0; i < 1024; i++) sram[i] <= 8'h00;
        else if (!sram_csb) begin
            en_cnt <= en_cnt + 1;
            if (!sram_web) begin
                sram[sram_addr] <= sram_din;
                wr_cnt <= wr_cnt + 1;
            end else sram_dout <= sram[sram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_csb"}, 32'(sram_csb), 32'd1);
        check({tag, "_web"}, 32'(sram_web), 32'd1);
        check({tag, "_addr"}, 32'(sram_addr), 32'd0);
        check({tag, "_din"}, 32'(sram_din), 32'd0);
        check({tag, "_ready"}, 32'(mem_ready), 32'd0);
        check({tag, "_rdata"}, mem_rdata, 32'd0);
        check({tag, "_ldready"}, 32'(ld_ready), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    function automatic logic [31:0] ref_word(input logic [9:0] a);
        ref_word = {ref_mem[{a[9:2], 2'd3}], ref_mem[{a[9:2], 2'd2}],
                    ref_mem[{a[9:2], 2'd1}], ref_mem[{a[9:2], 2'd0}]};
    endfunction

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    endtask

    task automatic cpu(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                       output logic [31:0] rd, output int lat, output logic zero_bad);
        wait_idle();
        mem_valid = 1; mem_addr = a; mem_wdata = wd; mem_wstrb = st; mem_instr = 1'($urandom);
        lat = 0; zero_bad = 0;
        do begin
            @(posedge clk); #1; lat++;
            if (lat == 1) begin mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom); end
            if (!mem_ready && mem_rdata !== 32'd0) zero_bad = 1;
        end while (!mem_ready && lat < 20);
        rd = mem_rdata;
        mem_valid = 0;
    endtask

    task automatic do_cpu(input string tag, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, output logic [31:0] rd);
        logic [31:0] exp;
        int lat;
        logic hit, zb;
        hit = a[31:10] == 22'd0;
        exp = 0;
        if (hit && st == 4'd0) exp = ref_word(a[9:0]);
        if (hit && st != 4'd0)
            for (int j = 0; j < 4; j++) if (st[j]) ref_mem[{a[9:2], 2'(j)}] = wd[8*j +: 8];
        cpu(a, wd, st, rd, lat, zb);
        check({tag, "_rdata"}, rd, exp);
        check({tag, "_lat"}, 32'(lat), hit ? 32'd6 : 32'd1);
        check({tag, "_idlezero"}, 32'(zb), 32'd0);
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(mem_ready), 32'd0);
    endtask

    task automatic do_ld(input string tag, input logic [9:0] a, input logic [7:0] d);
        int lat;
        ref_mem[a] = d;
        wait_idle();
        ld_valid = 1; ld_addr = a; ld_data = d; lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!ld_ready && lat < 20);
        ld_valid = 0;
        check({tag, "_lat"}, 32'(lat), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int w0, e0, lat, lat2;
        logic saw_ready;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 check_reset("reset");
        @(negedge clk); rst = 0; clr = 0;

        do_ld("ld10", 10'h010, 8'h11);
        do_ld("ld11", 10'h011, 8'h22);
        do_ld("ld12", 10'h012, 8'h33);
        do_ld("ld13", 10'h013, 8'h44);
        do_cpu("rd10", 32'h10, 32'h0, 4'h0, rd);
        check("rd10_const", rd, 32'h44332211);
        do_ld("ld40", 10'h040, 8'h11);
        do_ld("ld41", 10'h041, 8'h22);
        do_ld("ld42", 10'h042, 8'h33);
        do_ld("ld43", 10'h043, 8'h44);
        do_cpu("rd40", 32'h40, 32'h0, 4'h0, rd);
        check("rd40_const", rd, 32'h44332211);

        w0 = wr_cnt;
        do_cpu("wr40", 32'h40, 32'hAABBCCDD, 4'b0101, rd);
        check("wr40_cycles", 32'(wr_cnt - w0), 32'd2);
        do_cpu("rb40", 32'h40, 32'h0, 4'h0, rd);
        check("rb40_const", rd, 32'h44BB22DD);

        e0 = en_cnt;
        do_cpu("oor", 32'h0000_1000, 32'h0, 4'h0, rd);
        check("oor_err", 32'(err), 32'd1);
        check("oor_sram", 32'(en_cnt - e0), 32'd0);
        do_cpu("after_oor", 32'h10, 32'h0, 4'h0, rd);
        check("err_sticky", 32'(err), 32'd1);

        wait_idle();
        w0 = wr_cnt;
        mem_valid = 1; mem_addr = 32'h80; mem_wdata = 32'h87654321; mem_wstrb = 4'hF;
        repeat (3) begin @(posedge clk); #1; end
        check("abort_busy", 32'(busy), 32'd1);
        rst = 1;
        #1 check_reset("abort");
        @(negedge clk);
        check("abort_partial", 32'(wr_cnt - w0), 32'd2);
        ref_mem[10'h080] = 8'h21;
        ref_mem[10'h081] = 8'h43;
        rst = 0; mem_valid = 0;
        saw_ready = 0;
        repeat (8) begin @(posedge clk); #1; saw_ready |= mem_ready; end
        check("abort_noack", 32'(saw_ready), 32'd0);

        wait_idle();
        mem_valid = 1; mem_addr = 32'h10; mem_wdata = 0; mem_wstrb = 0;
        ld_valid = 1; ld_addr = 10'h200; ld_data = 8'h5A;
        ref_mem[10'h200] = 8'h5A;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!mem_ready && lat < 20);
        check("tie_cpu_lat", 32'(lat), 32'd6);
        check("tie_cpu_rdata", mem_rdata, ref_word(10'h010));
        check("tie_ld_wait", 32'(ld_ready), 32'd0);
        mem_valid = 0;
        lat2 = 0;
        do begin @(posedge clk); #1; lat2++; end while (!ld_ready && lat2 < 20);
        check("tie_ld_lat", 32'(lat2), 32'd2);
        ld_valid = 0;
        do_cpu("rd200", 32'h200, 32'h0, 4'h0, rd);
        do_cpu("rd80", 32'h80, 32'h0, 4'h0, rd);
        check("rd80_const", rd, 32'h00004321);

        for (int n = 0; n < 40; n++) begin
            logic [9:0] a;
            a = 10'($urandom_range(0, 63));
            case ($urandom_range(0, 2))
                0: do_ld("rnd_ld", a, 8'($urandom));
                1: do_cpu("rnd_wr", {22'd0, a}, $urandom, 4'($urandom), rd);
                default: do_cpu("rnd_rd", {22'd0, a}, $urandom, 4'h0, rd);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
